// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage. Runs one load/store per instruction on a
// single-outstanding data bus, passes non-memory results through, and holds
// the writeback value until the WB stage accepts it.

package memory_stage_pkg;

  // Pipeline control word carried alongside each instruction.
  typedef struct packed {
    logic       mem;         // instruction accesses data memory
    logic       iop;         // 1 = store, 0 = load
    logic [2:0] fcs_opcode;  // access size / signedness (funct3)
    logic [4:0] rd_addr;     // destination register
    logic       reg_write;   // writes the register file
  } control_s;

  function automatic control_s control_s_default();
    control_s c;
    c = '0;
    return c;
  endfunction

endpackage

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  control_s        i_control_signal,
  input  logic [XLEN-1:0] i_rd_output,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_be,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_valid,
  input  logic            i_wb_ready,
  output control_s        o_control_signal,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_fault
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_ACCESS,
    MEM_RESP
  } state_e;

  state_e          state;
  logic            ready_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]      addr_lo_q;

  logic            req_bad;
  logic [3:0]      req_be;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN-1:0] load_value;

  // The stage is idle-ready only once out of reset; ready_q tracks MEM_IDLE
  // as a registered copy so o_ready is forced low while reset is held.
  assign o_ready   = ready_q;
  assign o_mem_req = (state == MEM_ACCESS);
  assign o_valid   = (state == MEM_RESP);

  // Decode legality, byte enables and lane-replicated store data for the
  // instruction offered by execute.
  always_comb begin
    logic [2:0] op;
    logic [1:0] lo;
    logic       illegal;
    logic       misaligned;
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    op         = i_control_signal.fcs_opcode;
    lo         = i_rd_output[1:0];
    illegal    = 1'b0;
    misaligned = 1'b0;
    req_be     = 4'b1111;
    req_wdata  = i_rs2;

    if (i_control_signal.iop) begin
      illegal = !(op inside {3'b000, 3'b001, 3'b010});
    end else begin
      illegal = (op inside {3'b011, 3'b110, 3'b111});
    end

    misaligned = ((op[1:0] == 2'b01) && lo[0]) ||
                 ((op[1:0] == 2'b10) && (lo != 2'b00));
    req_bad    = illegal || misaligned;

    if (i_control_signal.iop) begin
      case (op[1:0])
        2'b00: begin
          req_be    = 4'b0001 << lo;
          req_wdata = {4{i_rs2[7:0]}};
        end
        2'b01: begin
          req_be    = 4'b0011 << lo;
          req_wdata = {2{i_rs2[15:0]}};
        end
        default: begin
          req_be    = 4'b1111;
          req_wdata = i_rs2;
        end
      endcase
    end
  end

  // Align the returned word to the accessed byte and extend to XLEN.
  always_comb begin
    logic [XLEN-1:0] shifted;
    shifted    = i_mem_rdata >> {addr_lo_q, 3'b000};
    load_value = shifted;
    case (o_control_signal.fcs_opcode)
      3'b000:  load_value = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_value = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_value = {24'd0, shifted[7:0]};
      3'b101:  load_value = {16'd0, shifted[15:0]};
      default: load_value = shifted;
    endcase
  end

  // Stage FSM: accept, bus access with timeout, and held response.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: every output register is cleared here so an access aborted by
    // reset leaves nothing behind on the bus or towards WB.
    if (!i_reset_n) begin
      state            <= MEM_IDLE;
      ready_q          <= 1'b0;
      cnt              <= '0;
      addr_lo_q        <= 2'b00;
      o_control_signal <= control_s_default();
      o_mem_we         <= 1'b0;
      o_mem_addr       <= '0;
      o_mem_wdata      <= '0;
      o_mem_be         <= 4'b0000;
      o_rd_data        <= '0;
      o_fault          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees
      // the pre-edge values of the others regardless of statement order.
      case (state)
        MEM_IDLE: begin
          ready_q <= 1'b1;
          if (i_valid && ready_q) begin
            ready_q          <= 1'b0;
            o_control_signal <= i_control_signal;
            addr_lo_q        <= i_rd_output[1:0];
            if (!i_control_signal.mem) begin
              state     <= MEM_RESP;
              o_rd_data <= i_rd_output;
              o_fault   <= 1'b0;
            end else if (req_bad) begin
              state     <= MEM_RESP;
              o_rd_data <= '0;
              o_fault   <= 1'b1;
            end else begin
              state       <= MEM_ACCESS;
              cnt         <= '0;
              o_fault     <= 1'b0;
              o_mem_we    <= i_control_signal.iop;
              o_mem_addr  <= {i_rd_output[XLEN-1:2], 2'b00};
              o_mem_be    <= req_be;
              o_mem_wdata <= req_wdata;
            end
          end
        end

        MEM_ACCESS: begin
          if (i_mem_ack || (cnt == CNT_LAST)) begin
            // An ack on the timeout edge takes priority over the fault.
            state       <= MEM_RESP;
            o_fault     <= !i_mem_ack;
            o_rd_data   <= (i_mem_ack && !o_control_signal.iop) ? load_value : '0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_be    <= 4'b0000;
            o_mem_wdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        MEM_RESP: begin
          if (i_wb_ready) begin
            state   <= MEM_IDLE;
            ready_q <= 1'b1;
            o_fault <= 1'b0;
          end
        end

        default: begin
          state   <= MEM_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM pipeline stage directly downstream of execute_stage.
- Consumes the execute result (effective address or ALU result), store data (rs2) and control_s; runs one load/store on a single-outstanding data-memory bus; presents the writeback value to the WB stage.
- Non-memory instructions pass through unchanged with one cycle of latency.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
TIMEOUT_CYCLES, 255, maximum cycles o_mem_req stays high without ack before a bus fault is raised; must be >= 1.

Ports:
i_clk  input  1  clock; all state changes on the rising edge.
i_reset_n  input  1  asynchronous, active-low reset.
i_valid  input  1  execute result valid.
o_ready  output  1  stage can accept; 1 only in MEM_IDLE while i_reset_n=1.
i_control_signal  input  control_s  uses .mem, .iop (1=store) and .fcs_opcode[2:0].
i_rd_output  input  XLEN  effective address (mem) or ALU result (non-mem).
i_rs2  input  XLEN  store data.
o_mem_req  output  1  bus request.
o_mem_we  output  1  1=write.
o_mem_addr  output  XLEN  word-aligned address: {addr[31:2],2'b00}.
o_mem_wdata  output  XLEN  lane-replicated store data.
o_mem_be  output  4  byte enables.
i_mem_ack  input  1  access complete; rdata valid in the same cycle.
i_mem_rdata  input  XLEN  read word.
o_valid  output  1  result valid to WB.
i_wb_ready  input  1  WB accepts.
o_control_signal  output  control_s  latched control.
o_rd_data  output  XLEN  writeback value.
o_fault  output  1  misaligned, illegal or timeout; qualified by o_valid.

Behaviour:
- States: MEM_IDLE, MEM_ACCESS, MEM_RESP.
- Reset (i_reset_n=0, any state, mid-access included):
  - State goes to MEM_IDLE.
  - All outputs are 0, including o_ready and o_mem_be; the latched control is control_s_default().
  - An aborted bus access is dropped; a late i_mem_ack is ignored.
- MEM_IDLE:
  - Transfer when i_valid && o_ready at the clock edge; latch control, address and rs2.
  - Non-mem instruction: next state MEM_RESP, o_rd_data = i_rd_output.
  - Mem instruction, illegal or misaligned: next state MEM_RESP, o_fault=1, o_rd_data=0, no bus request.
  - Otherwise: next state MEM_ACCESS, timeout counter cleared.
- Illegal encodings:
  - Load with fcs_opcode 011, 110 or 111.
  - Store with fcs_opcode other than 000, 001 or 010.
- Misaligned accesses:
  - Halfword (001/101) with addr[0]=1.
  - Word (010) with addr[1:0]!=0.
- MEM_ACCESS:
  - o_mem_req=1; o_mem_addr, o_mem_we, o_mem_be and o_mem_wdata stay stable until ack.
  - Byte store: be = 4'b0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - Half store: be = 4'b0011<<addr[1:0], wdata = {2{rs2[15:0]}}.
  - Word store: be = 4'b1111, wdata = rs2.
  - Load: be = 4'b1111, we = 0.
  - i_mem_ack=1 at the edge: go to MEM_RESP and drop o_mem_req the next cycle.
    - Load: shift rdata right by 8*addr[1:0], then LB/LH sign-extend and LBU/LHU zero-extend.
    - Store: o_rd_data=0.
  - Counter increments each cycle without ack. When it reaches TIMEOUT_CYCLES: MEM_RESP, o_fault=1, o_rd_data=0.
  - Ack on the same edge the timeout is reached: the ack wins, no fault.
  - i_mem_ack outside MEM_ACCESS is ignored.
- MEM_RESP:
  - o_valid=1; o_rd_data, o_fault and o_control_signal are held stable.
  - i_wb_ready at the edge: go to MEM_IDLE and clear o_valid and o_fault.
  - No accept in this state, so throughput is at most one instruction per 2 cycles (non-mem).
- Latency:
  - Non-mem: accept edge N, o_valid=1 in cycle N+1.
  - Memory: o_mem_req high from cycle N+1; ack at edge M gives o_valid=1 in cycle M+1.
  - Minimum memory latency is 2 cycles after accept.
- All output registers are reset asynchronously. o_ready and o_mem_req are decoded from the state register, with no combinational path from inputs.

Test Plan:
1. Mem control with fcs_opcode=000 (LB), iop=0, address 0x1003; memory returns 0x80xxxxxx with ack 2 cycles after req -> o_mem_addr=0x1000, be=4'b1111, o_rd_data=0xFFFFFF80, o_fault=0; LBU from the same address -> 0x00000080.
2. SH, address 0x2002, rs2=0xDEADBEEF -> o_mem_we=1, be=4'b1100, wdata=0xBEEFBEEF, o_rd_data=0 at o_valid.
3. LW at 0x2001 -> no o_mem_req ever, o_valid next cycle with o_fault=1. Store with fcs_opcode=100 -> o_fault=1.
4. Non-mem ALU result 0x12345678 with i_wb_ready held 0 for 3 cycles -> o_valid and data stable for 4 cycles, o_ready=0 throughout, returns to IDLE after the ready edge.
5. TIMEOUT_CYCLES=4, no ack -> req high exactly 4 cycles, then o_fault=1. Repeat with ack on the 4th edge -> no fault.
6. Assert i_reset_n=0 mid-MEM_ACCESS, then release and pulse a stray i_mem_ack -> outputs 0 immediately, state IDLE, stray ack ignored, o_ready=1 after release.
